// File: rtl/board_state_ram.sv
// Board cell RAM: one write port, two combinational read ports, a self-sequencing
// bulk-clear sweep (also run out of reset) and running black/white stone counters.
module board_state_ram #(
  parameter int BOARD_W = 8,
  parameter int BOARD_H = 8,
  parameter int ADDR_W  = 6,
  parameter int CELL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CELL_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [CELL_W-1:0] rd_data_out_1,
  output logic [CELL_W-1:0] rd_data_out_2,
  output logic [ADDR_W:0]   cnt_black,
  output logic [ADDR_W:0]   cnt_white
);

  localparam int DEPTH = BOARD_W * BOARD_H;
  // Range checks use one extra address bit so they stay meaningful when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [CELL_W-1:0] C_BLACK = CELL_W'(1);
  localparam logic [CELL_W-1:0] C_WHITE = CELL_W'(2);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W:0]   cnt_black_q, cnt_black_d;
  logic [ADDR_W:0]   cnt_white_q, cnt_white_d;
  logic              wr_drop_q, wr_drop_d;

  logic [CELL_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CELL_W-1:0] mem_wdata;

  logic              wr_in_range;
  logic [CELL_W-1:0] old_cell;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign old_cell    = wr_in_range ? mem_q[wr_addr] : '0;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    cnt_black_d = cnt_black_q;
    cnt_white_d = cnt_white_q;
    wr_drop_d   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr_q;
    mem_wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        wr_drop_d = wr_en;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d     = S_CLEAR;
          clr_ptr_d   = '0;
          cnt_black_d = '0;
          cnt_white_d = '0;
          wr_drop_d   = wr_en;
        end else if (wr_en) begin
          if (wr_in_range) begin
            mem_we      = 1'b1;
            mem_waddr   = wr_addr;
            mem_wdata   = wr_data;
            // Old and new cell both adjust the tallies on the same edge.
            cnt_black_d = cnt_black_q - (ADDR_W+1)'(old_cell == C_BLACK)
                                      + (ADDR_W+1)'(wr_data == C_BLACK);
            cnt_white_d = cnt_white_q - (ADDR_W+1)'(old_cell == C_WHITE)
                                      + (ADDR_W+1)'(wr_data == C_WHITE);
          end else begin
            wr_drop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_ptr_q   <= '0;
      cnt_black_q <= '0;
      cnt_white_q <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      cnt_black_q <= cnt_black_d;
      cnt_white_q <= cnt_white_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // Array has no reset; the sweep that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data_out_1 = ({1'b0, rd_addr_1} < DEPTH_X) ? mem_q[rd_addr_1] : '0;
  assign rd_data_out_2 = ({1'b0, rd_addr_2} < DEPTH_X) ? mem_q[rd_addr_2] : '0;

  assign busy      = (state_q == S_CLEAR);
  assign wr_drop   = wr_drop_q;
  assign cnt_black = cnt_black_q;
  assign cnt_white = cnt_white_q;

endmodule

// File: tb/tb_board_state_ram.sv
// Scoreboard bench for board_state_ram: an 8x8 and a 9x9 instance run against a
// cell-array reference model; expectations are queued and checked at negedge.
module tb_board_state_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, clr_a, we_a, busy_a, drop_a;
  logic [5:0] wa_a, r1_a, r2_a;
  logic [1:0] wd_a, q1_a, q2_a;
  logic [6:0] cb_a, cw_a;

  logic       rst_b, clr_b, we_b, busy_b, drop_b;
  logic [6:0] wa_b, r1_b, r2_b;
  logic [1:0] wd_b, q1_b, q2_b;
  logic [7:0] cb_b, cw_b;

  board_state_ram #(.BOARD_W(8), .BOARD_H(8), .ADDR_W(6), .CELL_W(2)) u_a (
    .clk(clk), .rst(rst_a), .clr_req(clr_a), .busy(busy_a),
    .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a), .wr_drop(drop_a),
    .rd_addr_1(r1_a), .rd_addr_2(r2_a), .rd_data_out_1(q1_a), .rd_data_out_2(q2_a),
    .cnt_black(cb_a), .cnt_white(cw_a));

  board_state_ram #(.BOARD_W(9), .BOARD_H(9), .ADDR_W(7), .CELL_W(2)) u_b (
    .clk(clk), .rst(rst_b), .clr_req(clr_b), .busy(busy_b),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .wr_drop(drop_b),
    .rd_addr_1(r1_b), .rd_addr_2(r2_b), .rd_data_out_1(q1_b), .rd_data_out_2(q2_b),
    .cnt_black(cb_b), .cnt_white(cw_b));

  // Reference model: cell contents (-1 = unknown since power-up), cycles of sweep left.
  int depth [2] = '{64, 81};
  int ref_mem [2][128];
  int busy_left [2];
  int drop_exp [2];

  typedef struct {int sel; int exp;} exp_t;
  exp_t sb [$];
  string nm [6] = '{"busy", "wr_drop", "cnt_black", "cnt_white", "rd1", "rd2"};
  int n_vec = 0;
  int n_err = 0;

  function automatic int tally(int d, int v);
    int n = 0;
    for (int i = 0; i < depth[d]; i++) if (ref_mem[d][i] == v) n++;
    return n;
  endfunction

  function automatic void model_reset(int d);
    busy_left[d] = depth[d];
    drop_exp[d] = 0;
  endfunction

  function automatic void model_edge(int d, int clr, int we, int addr, int data);
    drop_exp[d] = 0;
    if (busy_left[d] > 0) begin
      ref_mem[d][depth[d] - busy_left[d]] = 0;
      busy_left[d]--;
      drop_exp[d] = we;
    end else if (clr != 0) begin
      busy_left[d] = depth[d];
      drop_exp[d] = we;
    end else if (we != 0) begin
      if (addr < depth[d]) ref_mem[d][addr] = data;
      else drop_exp[d] = 1;
    end
  endfunction

  function automatic int exp_rd(int d, int addr);
    if (addr >= depth[d]) return 0;
    return ref_mem[d][addr];
  endfunction

  function automatic int actual(int sel);
    case (sel)
      0: return int'(busy_a);
      1: return int'(drop_a);
      2: return int'(cb_a);
      3: return int'(cw_a);
      4: return int'(q1_a);
      5: return int'(q2_a);
      8: return int'(busy_b);
      9: return int'(drop_b);
      10: return int'(cb_b);
      11: return int'(cw_b);
      12: return int'(q1_b);
      13: return int'(q2_b);
      default: return -99;
    endcase
  endfunction

  task automatic check_now(string what, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", what, $time, got, exp);
    end
  endtask

  task automatic check_reset_state();
    #1;
    check_now("reset busy_a", int'(busy_a), 1);
    check_now("reset cnt_black_a", int'(cb_a), 0);
    check_now("reset cnt_white_a", int'(cw_a), 0);
    check_now("reset wr_drop_a", int'(drop_a), 0);
  endtask

  task automatic check_wait_expired(int d);
    #1;
    if (d == 0) begin
      check_now("expired busy_a", int'(busy_a), 0);
    end else begin
      check_now("expired busy_b", int'(busy_b), 0);
    end
  endtask

  task automatic push(int sel, int e);
    exp_t x;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic chk();
    int e;
    for (int d = 0; d < 2; d++) begin
      push(d*8 + 0, (busy_left[d] > 0) ? 1 : 0);
      push(d*8 + 1, drop_exp[d]);
      push(d*8 + 2, (busy_left[d] > 0) ? 0 : tally(d, 1));
      push(d*8 + 3, (busy_left[d] > 0) ? 0 : tally(d, 2));
      e = exp_rd(d, (d == 0) ? int'(r1_a) : int'(r1_b));
      if (e >= 0) push(d*8 + 4, e);
      e = exp_rd(d, (d == 0) ? int'(r2_a) : int'(r2_b));
      if (e >= 0) push(d*8 + 5, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_a) model_edge(0, int'(clr_a), int'(we_a), int'(wa_a), int'(wd_a));
    if (!rst_b) model_edge(1, int'(clr_b), int'(we_b), int'(wa_b), int'(wd_b));
    #1;
    clr_a = 1'b0; we_a = 1'b0; clr_b = 1'b0; we_b = 1'b0;
    r1_a = 6'($urandom_range(63));  r2_a = 6'($urandom_range(63));
    r1_b = 7'($urandom_range(127)); r2_b = 7'($urandom_range(127));
  endtask

  task automatic cyc();
    chk();
    step();
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(int d, int addr, int data);
    if (d == 0) begin
      we_a = 1'b1; wa_a = 6'(addr); wd_a = 2'(data);
    end else begin
      we_b = 1'b1; wa_b = 7'(addr); wd_b = 2'(data);
    end
    cyc();
  endtask

  task automatic sweep_a();
    for (int i = 0; i < 64; i++) begin
      r1_a = 6'(i);
      r2_a = 6'((i + 17) % 64);
      cyc();
    end
  endtask

  task automatic fill_a();
    for (int i = 0; i < 64; i++) wr(0, i, int'($urandom_range(3)));
  endtask

  exp_t mon_e;
  int   mon_a;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = actual(mon_e.sel);
      n_vec++;
      if (mon_a != mon_e.exp) begin
        n_err++;
        $display("FAIL %s.%s at %0t: got %0d expected %0d",
                 (mon_e.sel >= 8) ? "dut9x9" : "dut8x8", nm[mon_e.sel % 8], $time, mon_a, mon_e.exp);
      end
    end
  end

  initial begin
    rst_a = 1'b1; clr_a = 1'b0; we_a = 1'b0; wa_a = '0; wd_a = '0; r1_a = '0; r2_a = '0;
    rst_b = 1'b1; clr_b = 1'b0; we_b = 1'b0; wa_b = '0; wd_b = '0; r1_b = '0; r2_b = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 128; i++) ref_mem[d][i] = -1;
      model_reset(d);
    end
    check_reset_state();
    #1;
    check_now("reset busy_b", int'(busy_b), 1);
    check_now("reset cnt_black_b", int'(cb_b), 0);
    check_now("reset cnt_white_b", int'(cw_b), 0);
    check_now("reset wr_drop_b", int'(drop_b), 0);
    cycn(2);
    rst_a = 1'b0;
    rst_b = 1'b0;
    cycn(85);
    check_wait_expired(0);
    check_wait_expired(1);
    check_now("expired cnt_black_a", int'(cb_a), 0);
    check_now("expired cnt_white_a", int'(cw_a), 0);
    check_now("expired cnt_black_b", int'(cb_b), 0);
    check_now("expired cnt_white_b", int'(cw_b), 0);
    sweep_a();

    // Directed counter updates, including same-cycle read of the written cell
    wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 1); cyc();
    wr(0, 0, 2); cyc();
    wr(0, 1, 0); cyc();
    r1_a = 6'd3;
    wr(0, 3, 3);
    r1_a = 6'd3; r2_a = 6'd0;
    cyc();

    fill_a();
    sweep_a();

    // Asynchronous reset from idle with non-zero counters
    rst_a = 1'b1; model_reset(0);
    check_reset_state();
    cycn(2);
    rst_a = 1'b0;
    cycn(66);
    check_wait_expired(0);
    sweep_a();

    // Clear accepted together with a write, traffic and a second request mid-sweep
    fill_a();
    clr_a = 1'b1; we_a = 1'b1; wa_a = 6'd5; wd_a = 2'd1;
    cyc();
    for (int k = 1; k <= 70; k++) begin
      if (k == 10) clr_a = 1'b1;
      if (k % 3 == 0) begin
        we_a = 1'b1; wa_a = 6'($urandom_range(63)); wd_a = 2'($urandom_range(3));
      end
      cyc();
    end
    sweep_a();

    // Reset at cycle 20 of a sweep
    fill_a();
    clr_a = 1'b1;
    cycn(20);
    rst_a = 1'b1; model_reset(0);
    check_reset_state();
    cycn(2);
    rst_a = 1'b0;
    cycn(66);
    check_wait_expired(0);
    sweep_a();

    // 9x9 board: random traffic including out-of-range addresses, then boundaries
    for (int k = 0; k < 150; k++) begin
      we_b = 1'($urandom_range(1));
      wa_b = 7'($urandom_range(127));
      wd_b = 2'($urandom_range(3));
      cyc();
    end
    wr(1, 81, 1);
    r2_b = 7'd100;
    wr(1, 80, 2);
    r1_b = 7'd80; r2_b = 7'd100;
    cyc();
    clr_b = 1'b1;
    cycn(85);
    check_wait_expired(1);
    for (int i = 0; i < 81; i++) begin
      r1_b = 7'(i);
      r2_b = 7'(80 - i);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
